fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter, drives `pc_address`, and captures the combinational `instruction` into an instruction register.
- Decodes the 9-bit word into opcode and register fields, then hands it to the execute stage over a valid/ready handshake.
- Supports stall, jump/redirect, and halt-at-end-of-program.

Parameters:
- ADDR_W, 8, PC and memory address width (256 words)
- INSTR_W, 9, instruction width: opcode[8:6], rd[5:3], rs[2:0]
- LAST_ADDR, 255, address of the final instruction of the program
- WRAP, 0, 1 = PC wraps to 0 after LAST_ADDR; 0 = halt after LAST_ADDR

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; 0 = no new fetches (held handshake unaffected)
- pc_address  out  ADDR_W  address to instruction memory (= PC register)
- instruction  in  INSTR_W  combinational memory data for pc_address
- jump_valid  in  1  redirect request, single-cycle pulse
- jump_target  in  ADDR_W  redirect address
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute stage accepts
- opcode  out  3  instruction[8:6]
- rd  out  3  instruction[5:3]
- rs  out  3  instruction[2:0]
- uses_rs  out  1  0 for NOT/SHL/SHR (opcode 101/110/111), else 1
- instr_pc  out  ADDR_W  address the held instruction was fetched from
- halted  out  1  high in S_HALT

Behaviour:
- Reset (async, immediate):
  - pc = 0; out_valid = 0; opcode/rd/rs/instr_pc = 0; uses_rs = 1; halted = 0; state = S_IDLE.
- States:
  - S_IDLE: en = 0.
  - S_RUN: fetching.
  - S_HALT: program end reached.
- State transitions:
  - IDLE -> RUN when en = 1.
  - RUN -> IDLE when en = 0.
  - RUN -> HALT on capture at LAST_ADDR with WRAP = 0.
  - HALT -> RUN only on jump_valid.
  - Any state: jump_valid sets pc and goes to RUN if en, else IDLE.
- Slot free: `slot_free = !out_valid || out_ready`.
- Fetch:
  - Occurs in S_RUN when slot_free and !jump_valid.
  - IR/decode regs <= instruction; instr_pc <= pc; out_valid <= 1; pc <= pc + 1 (mod 2^ADDR_W).
  - Memory is combinational: the instruction is sampled in the same cycle pc_address is presented.
  - Fetch-to-out_valid latency: 1 cycle. Throughput: 1 instruction/cycle when out_ready is held high.
- Stall: out_valid && !out_ready -> pc, IR, decode outputs and out_valid are all frozen.
- Drain (no fetch: en = 0 or S_HALT):
  - out_valid && out_ready -> out_valid <= 0.
  - Outputs hold their last values while out_valid = 0.
- End of program:
  - Capture at pc == LAST_ADDR, WRAP = 0: pc stays LAST_ADDR, state -> S_HALT, halted = 1 next cycle. That last instruction is still delivered.
  - WRAP = 1: pc <= 0, stay in S_RUN.
- Jump (priority over fetch and stall):
  - pc <= jump_target; out_valid <= 0 (held instruction flushed, even if stalled); halted <= 0.
  - First post-jump fetch happens in the following cycle.
- Simultaneous events:
  - jump_valid with out_ready -> treated as handshake completion plus flush.
  - jump_valid while en = 0 -> pc updated, no fetch until en = 1.
- Reset mid-stall or mid-halt: everything returns to reset values asynchronously; no partial state survives.

Decomposition:
- Package cpu_pkg:
  - ADDR_W, INSTR_W, field-position constants.
  - Opcode localparams OP_ADD = 000, OP_SUB = 001, OP_AND = 010, OP_OR = 011, OP_XOR = 100, OP_NOT = 101, OP_SHL = 110, OP_SHR = 111.
  - State encoding S_IDLE, S_RUN, S_HALT.
- One sub-module: instr_decoder (combinational) — field split and uses_rs. It is instantiated on the IR input so the decoded fields are registered.

Test Plan:
- Reset, en = 1, out_ready = 1, memory loaded with the 8-instruction program:
  - cycles 1..8 -> out_valid = 1, instr_pc = 0..7; opcode/rd/rs = 000/000/001, 001/010/011, 010/001/100, 011/011/010, 100/000/001, 101/001/000, 110/010/000, 111/011/000.
  - uses_rs = 0 for the last three.
- out_ready = 0 for 3 cycles while instr_pc = 2 -> pc_address stays 3; opcode = 010, rd = 001, rs = 100 held. On release, instr_pc = 3 follows in the next cycle.
- LAST_ADDR = 7, WRAP = 0 -> instruction at 7 delivered, halted = 1, pc_address = 7, out_valid = 0 after acceptance. Same config with WRAP = 1 -> instr_pc sequence 6, 7, 0, 1.
- jump_valid with jump_target = 5 while stalled holding instr_pc = 1 -> next cycle out_valid = 0, pc_address = 5. Following cycle out_valid = 1, instr_pc = 5, opcode = 101, uses_rs = 0. Jump from S_HALT resumes and clears halted.
- en toggled 1 -> 0 after two fetches -> the held instruction drains, pc_address stays 2, no new out_valid. en = 1 -> resumes at instr_pc = 2.
- Assert rst asynchronously mid-stall (not on a clock edge) -> pc_address = 0 and out_valid = 0 immediately. After release, first delivered instr_pc = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, instruction field layout, opcodes and fetch FSM encoding
// for the instruction fetch path.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       uses_rs;
  } dec_t;

  localparam dec_t DEC_RST = '{opcode: 3'b000, rd: 3'b000, rs: 3'b000, uses_rs: 1'b1};

  // Unary and shift ops take only rd; everything else reads rs as well.
  function automatic logic op_uses_rs(input logic [2:0] op);
    return !(op == OP_NOT || op == OP_SHL || op == OP_SHR);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field split of a raw instruction word; the fetch unit
// registers its output together with the instruction register.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  always_comb begin
    dec         = DEC_RST;
    dec.opcode  = instr[OPC_MSB:OPC_LSB];
    dec.rd      = instr[RD_MSB:RD_LSB];
    dec.rs      = instr[RS_MSB:RS_LSB];
    dec.uses_rs = op_uses_rs(instr[OPC_MSB:OPC_LSB]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures combinational memory data into a
// decoded instruction register and offers it to execute over valid/ready.
//
// state  | meaning
// S_IDLE | en low, no fetches
// S_RUN  | fetching while the output slot is free
// S_HALT | last program address captured, waits for a jump
module fetch_unit #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 9,
  parameter int LAST_ADDR = 255,
  parameter bit WRAP      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [ADDR_W-1:0]  pc_address,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs,
  output logic               uses_rs,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  import cpu_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              out_valid_q, out_valid_d;
  dec_t              dec_q, dec_d;
  dec_t              dec_in;

  logic slot_free;
  logic fetch;
  logic at_last;

  instr_decoder u_instr_decoder (
    .instr (instruction),
    .dec   (dec_in)
  );

  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    fetch       = (state_q == S_RUN) && en && slot_free && !jump_valid;
    at_last     = (pc_q == ADDR_W'(LAST_ADDR));

    state_d     = state_q;
    pc_d        = pc_q;
    instr_pc_d  = instr_pc_q;
    out_valid_d = out_valid_q;
    dec_d       = dec_q;

    if (jump_valid) begin
      // Redirect flushes the held instruction even when execute is stalling.
      pc_d        = jump_target;
      out_valid_d = 1'b0;
      state_d     = en ? S_RUN : S_IDLE;
    end else begin
      if (fetch) begin
        dec_d       = dec_in;
        instr_pc_d  = pc_q;
        out_valid_d = 1'b1;
        if (at_last) begin
          pc_d = WRAP ? '0 : pc_q;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end

      case (state_q)
        S_IDLE: if (en) state_d = S_RUN;
        S_RUN: begin
          if (!en) begin
            state_d = S_IDLE;
          end else if (fetch && at_last && !WRAP) begin
            state_d = S_HALT;
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_pc_q  <= '0;
      out_valid_q <= 1'b0;
      dec_q       <= DEC_RST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_pc_q  <= instr_pc_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
    end
  end

  assign pc_address = pc_q;
  assign out_valid  = out_valid_q;
  assign opcode     = dec_q.opcode;
  assign rd         = dec_q.rd;
  assign rs         = dec_q.rs;
  assign uses_rs    = dec_q.uses_rs;
  assign instr_pc   = instr_pc_q;
  assign halted     = (state_q == S_HALT);

endmodule
